pixel_shift_buffer: RTL and testbench

- Parametrised frame buffer and bit serialiser for a chain of addressable LEDs.
- Holds NUM_LEDS pixels of BITS_PER_LED bits each and presents them MSB-first, one bit at a time, to the downstream bit-waveform generator.
- Advances one bit on each generator completion pulse and signals end of frame.
- Sits between the pixel source (frame loader) and the bit-waveform generator.

---
 rtl/pixel_shift_buffer_if.sv | 39 +++
 rtl/pixel_shift_buffer.sv | 154 +++++++++++++++
 tb/tb_pixel_shift_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_shift_buffer_if.sv
// Handshake bundle between frame loader, pixel_shift_buffer and the bit-waveform generator.
// TOTAL must equal NUM_LEDS*BITS_PER_LED of the attached buffer.
interface pixel_shift_buffer_if #(
   parameter int TOTAL = 96
) ();
   logic             load_valid;
   logic             load_ready;
   logic [TOTAL-1:0] load_data;
   logic             start;
   logic             bit_out;
   logic             bit_valid;
   logic             bit_done;
   logic             frame_done;
   logic             busy;

   modport master (
      output load_valid,
      output load_data,
      output start,
      output bit_done,
      input  load_ready,
      input  bit_out,
      input  bit_valid,
      input  frame_done,
      input  busy
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  start,
      input  bit_done,
      output load_ready,
      output bit_out,
      output bit_valid,
      output frame_done,
      output busy
   );
endinterface

// File: rtl/pixel_shift_buffer.sv
// Frame buffer + MSB-first bit serialiser for an addressable LED chain, one bit per bit_done pulse.
// Define PIXEL_SHIFT_BUFFER_SHADOW_EN for a double-buffered loader that never stalls the frame source.
module pixel_shift_buffer #(
   parameter int                      NUM_LEDS      = 4,
   parameter int                      BITS_PER_LED  = 24,
   parameter logic [BITS_PER_LED-1:0] DEFAULT_PIXEL = 24'h0F0F0F,
   parameter bit                      ROTATE        = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   pixel_shift_buffer_if.slave bus
);
   localparam int               TOTAL         = NUM_LEDS * BITS_PER_LED;
   localparam int               CW            = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [TOTAL-1:0] DEFAULT_FRAME = {NUM_LEDS{DEFAULT_PIXEL}};
   localparam logic [CW-1:0]    LAST_BIT      = CW'(TOTAL - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t           state_r;
   logic [TOTAL-1:0] frame_r;
   logic [CW-1:0]    cnt_r;
   logic             bit_valid_r;
   logic             busy_r;
   logic             frame_done_r;

   // Shift-by-one written without part-selects so TOTAL == 1 elaborates cleanly.
   function automatic logic [TOTAL-1:0] advance(input logic [TOTAL-1:0] s);
      logic [TOTAL-1:0] n;
      n = s << 1'b1;
      if (ROTATE) begin
         n[0] = s[TOTAL-1];
      end else begin
         n[0] = 1'b0;
      end
      return n;
   endfunction

`ifdef PIXEL_SHIFT_BUFFER_SHADOW_EN
   logic [TOTAL-1:0] shadow_r;
   logic             pending_r;

   assign bus.load_ready = 1'b1;
`else
   logic             load_ready_r;
   logic             load_fire_s;

   assign load_fire_s    = bus.load_valid & load_ready_r;
   assign bus.load_ready = load_ready_r;
`endif

   assign bus.bit_out    = frame_r[TOTAL-1];
   assign bus.bit_valid  = bit_valid_r;
   assign bus.busy       = busy_r;
   assign bus.frame_done = frame_done_r;

   // Control FSM plus frame/shadow datapath; every output is a register bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         frame_r      <= DEFAULT_FRAME;
         cnt_r        <= '0;
         bit_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
`ifdef PIXEL_SHIFT_BUFFER_SHADOW_EN
         shadow_r     <= DEFAULT_FRAME;
         pending_r    <= 1'b0;
`else
         load_ready_r <= 1'b1;
`endif
      end else begin
         frame_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
`ifdef PIXEL_SHIFT_BUFFER_SHADOW_EN
               if (bus.start) begin
                  // A load coinciding with start wins over any older pending frame.
                  if (bus.load_valid) begin
                     frame_r <= bus.load_data;
                  end else if (pending_r) begin
                     frame_r <= shadow_r;
                  end else begin
                     frame_r <= frame_r;
                  end
                  pending_r   <= 1'b0;
                  state_r     <= ST_SEND;
                  bit_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end else if (bus.load_valid) begin
                  shadow_r  <= bus.load_data;
                  pending_r <= 1'b1;
               end else begin
                  pending_r <= pending_r;
               end
`else
               if (load_fire_s) begin
                  frame_r <= bus.load_data;
               end else begin
                  frame_r <= frame_r;
               end
               if (bus.start) begin
                  state_r      <= ST_SEND;
                  bit_valid_r  <= 1'b1;
                  busy_r       <= 1'b1;
                  load_ready_r <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
               end
`endif
            end
            ST_SEND: begin
`ifdef PIXEL_SHIFT_BUFFER_SHADOW_EN
               if (bus.load_valid) begin
                  shadow_r  <= bus.load_data;
                  pending_r <= 1'b1;
               end else begin
                  pending_r <= pending_r;
               end
`endif
               if (bus.bit_done) begin
                  frame_r <= advance(frame_r);
                  if (cnt_r == LAST_BIT) begin
                     cnt_r        <= '0;
                     state_r      <= ST_IDLE;
                     bit_valid_r  <= 1'b0;
                     busy_r       <= 1'b0;
                     frame_done_r <= 1'b1;
`ifndef PIXEL_SHIFT_BUFFER_SHADOW_EN
                     load_ready_r <= 1'b1;
`endif
                  end else begin
                     cnt_r <= cnt_r + CW'(1'b1);
                  end
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= '0;
               bit_valid_r <= 1'b0;
               busy_r      <= 1'b0;
`ifndef PIXEL_SHIFT_BUFFER_SHADOW_EN
               load_ready_r <= 1'b1;
`endif
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pixel_shift_buffer.sv
// Directed bench: ROTATE=1 and ROTATE=0 buffers share stimulus; frame vectors in a table plus reset-abort sequence.
module tb_pixel_shift_buffer;
   localparam int          TOTAL     = 96;
   localparam logic [95:0] DEF_FRAME = {4{24'h0F0F0F}};
   localparam logic [95:0] ONES      = {96{1'b1}};
`ifdef PIXEL_SHIFT_BUFFER_SHADOW_EN
   localparam bit          LR_SEND   = 1'b1;
   localparam logic [95:0] AFTER_MID = ONES;
`else
   localparam bit          LR_SEND   = 1'b0;
   localparam logic [95:0] AFTER_MID = DEF_FRAME;
`endif

   typedef struct {
      bit          sel;        // 0: ROTATE=1 buffer, 1: ROTATE=0 buffer
      int          do_load;    // 0 none, 1 load then start, 2 load with start
      logic [95:0] data;
      logic [95:0] exp;
      int          gap;        // idle cycles before each bit_done
      bit          hold_start; // keep start high during SEND
      int          mid_load;   // bit index at which a load is attempted in SEND, -1 none
      logic [95:0] mid_data;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        load_valid;
   logic [95:0] load_data;
   logic        start;
   logic        bit_done;
   int          n_cmp;
   int          n_bad;
   vec_t        vecs[8];

   pixel_shift_buffer_if #(.TOTAL(TOTAL)) bus_r ();
   pixel_shift_buffer_if #(.TOTAL(TOTAL)) bus_z ();

   assign bus_r.load_valid = load_valid;
   assign bus_r.load_data  = load_data;
   assign bus_r.start      = start;
   assign bus_r.bit_done   = bit_done;
   assign bus_z.load_valid = load_valid;
   assign bus_z.load_data  = load_data;
   assign bus_z.start      = start;
   assign bus_z.bit_done   = bit_done;

   pixel_shift_buffer #(.NUM_LEDS(4), .BITS_PER_LED(24), .DEFAULT_PIXEL(24'h0F0F0F), .ROTATE(1'b1))
      dut_rot (.clk(clk), .reset(reset), .bus(bus_r));
   pixel_shift_buffer #(.NUM_LEDS(4), .BITS_PER_LED(24), .DEFAULT_PIXEL(24'h0F0F0F), .ROTATE(1'b0))
      dut_zero (.clk(clk), .reset(reset), .bus(bus_z));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {bit_out, bit_valid, busy, frame_done, load_ready}
   function automatic logic [4:0] outs(input bit sel);
      if (sel) return {bus_z.bit_out, bus_z.bit_valid, bus_z.busy, bus_z.frame_done, bus_z.load_ready};
      else     return {bus_r.bit_out, bus_r.bit_valid, bus_r.busy, bus_r.frame_done, bus_r.load_ready};
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [4:0] o;
      int         cycles;
      if (v.do_load == 1) begin
         load_valid = 1'b1;
         load_data  = v.data;
         o = outs(v.sel);
         chk($sformatf("v%0d idle load_ready", idx), {95'd0, o[0]}, 96'd1);
         step();
         load_valid = 1'b0;
      end
      start = 1'b1;
      if (v.do_load == 2) begin
         load_valid = 1'b1;
         load_data  = v.data;
      end
      step();
      load_valid = 1'b0;
      start      = v.hold_start;
      o = outs(v.sel);
      chk($sformatf("v%0d started valid/busy/done", idx), {93'd0, o[3:1]}, 96'b110);
      cycles = 0;
      for (int i = 0; i < 96; i++) begin
         o = outs(v.sel);
         chk($sformatf("v%0d bit%0d", idx, i), {95'd0, o[4]}, {95'd0, v.exp[95-i]});
         chk($sformatf("v%0d bit%0d load_ready", idx, i), {95'd0, o[0]}, {95'd0, LR_SEND});
         for (int g = 0; g < v.gap; g++) begin
            bit_done = 1'b0;
            step();
            cycles++;
            o = outs(v.sel);
            chk($sformatf("v%0d bit%0d hold", idx, i), {95'd0, o[4]}, {95'd0, v.exp[95-i]});
         end
         if (i == v.mid_load) begin
            load_valid = 1'b1;
            load_data  = v.mid_data;
         end
         bit_done = 1'b1;
         step();
         cycles++;
         load_valid = 1'b0;
         if (i < 95) begin
            o = outs(v.sel);
            chk($sformatf("v%0d bit%0d busy/done", idx, i), {94'd0, o[2:1]}, 96'b10);
         end
      end
      bit_done = 1'b0;
      start    = 1'b0;
      o = outs(v.sel);
      chk($sformatf("v%0d end valid/busy/done/ready", idx), {92'd0, o[3:0]}, 96'b0011);
      chk($sformatf("v%0d cycles", idx), 96'(cycles), 96'(96 * (v.gap + 1)));
      step();
      o = outs(v.sel);
      chk($sformatf("v%0d done one-shot", idx), {95'd0, o[1]}, 96'd0);
   endtask

   initial begin
      logic [4:0] o;
      vec_t       dv;
      n_cmp      = 0;
      n_bad      = 0;
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      start      = 1'b0;
      bit_done   = 1'b0;

      //           sel   ld    data                         exp                          gap  hold  mid  mid_data
      vecs[0] = '{1'b0, 0, 96'd0,                        DEF_FRAME,                   0, 1'b0, -1, 96'd0};
      vecs[1] = '{1'b1, 0, 96'd0,                        96'd0,                       0, 1'b0, -1, 96'd0};
      vecs[2] = '{1'b0, 0, 96'd0,                        DEF_FRAME,                   1, 1'b0, -1, 96'd0};
      vecs[3] = '{1'b0, 0, 96'd0,                        DEF_FRAME,                   0, 1'b0, 10, ONES};
      vecs[4] = '{1'b0, 0, 96'd0,                        AFTER_MID,                   0, 1'b0, -1, 96'd0};
      vecs[5] = '{1'b0, 1, 96'h800000_000000_000000_000001, 96'h800000_000000_000000_000001, 0, 1'b0, -1, 96'd0};
      vecs[6] = '{1'b0, 2, 96'hA5A5A5_123456_FEDCBA_000FF0, 96'hA5A5A5_123456_FEDCBA_000FF0, 0, 1'b1, -1, 96'd0};
      vecs[7] = '{1'b0, 1, 96'h123456_789ABC_DEF013_579BDF, 96'h123456_789ABC_DEF013_579BDF, 2, 1'b0, -1, 96'd0};

      step();
      step();
      o = outs(1'b0);
      chk("reset rot outputs", {91'd0, o}, 96'b00001);
      o = outs(1'b1);
      chk("reset zero outputs", {91'd0, o}, 96'b00001);
      reset = 1'b0;
      step();
      o = outs(1'b0);
      chk("idle after reset", {91'd0, o}, 96'b00001);

      for (int k = 0; k < 8; k++) begin
         run_vec(vecs[k], k);
      end

      // Reset partway through a frame aborts it without a frame_done pulse.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bit_done = 1'b1;
         step();
      end
      bit_done = 1'b0;
      o = outs(1'b0);
      chk("abort pre-reset busy", {95'd0, o[2]}, 96'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      o = outs(1'b0);
      chk("abort rot outputs", {91'd0, o}, 96'b00001);
      o = outs(1'b1);
      chk("abort zero outputs", {91'd0, o}, 96'b00001);
      for (int i = 0; i < 5; i++) begin
         bit_done = 1'b1;
         step();
         o = outs(1'b0);
         chk($sformatf("idle bit_done %0d", i), {91'd0, o}, 96'b00001);
      end
      bit_done = 1'b0;
      dv = '{1'b0, 0, 96'd0, DEF_FRAME, 0, 1'b0, -1, 96'd0};
      run_vec(dv, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
